// File: rtl/esd_pkg.sv
// Shared state encoding and default timing constants for the ESD host supervisor.
package esd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACK     = 3'd2,
    ST_VERIFY  = 3'd3,
    ST_RUN     = 3'd4,
    ST_TRIP    = 3'd5,
    ST_LOCKOUT = 3'd6
  } state_e;

  localparam int unsigned KICK_PERIOD_CYC_DEF = 10_000_000;
  localparam int unsigned KICK_WIDTH_CYC_DEF  = 2;
  localparam int unsigned SETTLE_CYC_DEF      = 1000;
  localparam int unsigned ACK_WIDTH_CYC_DEF   = 10;
  localparam int unsigned VERIFY_CYC_DEF      = 100_000;
  localparam int unsigned RETRY_MAX_DEF       = 3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/esd_kick_gen.sv
// Periodic watchdog kick: phase counter wraps at PERIOD_CYC, pulse high for WIDTH_CYC.
module esd_kick_gen
  import esd_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = KICK_PERIOD_CYC_DEF,
  parameter int unsigned WIDTH_CYC  = KICK_WIDTH_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic inhibit,
  output logic kick
);

  localparam int unsigned PW = $clog2(PERIOD_CYC + 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          kick_q, kick_d;

  always_comb begin
    phase_d = phase_q;
    kick_d  = 1'b0;
    if (!active) begin
      phase_d = '0;
    end else if (!inhibit) begin
      kick_d  = (phase_q < PW'(WIDTH_CYC));
      phase_d = (phase_q == PW'(PERIOD_CYC - 1)) ? '0 : phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      kick_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      kick_q  <= kick_d;
    end
  end

  assign kick = kick_q;

endmodule

// File: rtl/esd_host_supervisor.sv
// Host-side ESD supervisor: kicks the controller watchdog and re-arms it after trips.
// Optional ESD_SUP_KICK_INJECT_EN adds kick_inhibit to suppress kicks for system test.
module esd_host_supervisor
  import esd_pkg::*;
#(
  parameter int unsigned KICK_PERIOD_CYC = KICK_PERIOD_CYC_DEF,
  parameter int unsigned KICK_WIDTH_CYC  = KICK_WIDTH_CYC_DEF,
  parameter int unsigned SETTLE_CYC      = SETTLE_CYC_DEF,
  parameter int unsigned ACK_WIDTH_CYC   = ACK_WIDTH_CYC_DEF,
  parameter int unsigned VERIFY_CYC      = VERIFY_CYC_DEF,
  parameter int unsigned RETRY_MAX       = RETRY_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       estop_a_n,
  input  logic       estop_b_n,
  input  logic       shutdown_in,
  input  logic       fault_clr,
`ifdef ESD_SUP_KICK_INJECT_EN
  input  logic       kick_inhibit,
`endif
  output logic       wdg_kick,
  output logic       ack_n,
  output logic       run_ok,
  output logic       fault,
  output logic [7:0] trip_cnt,
  output logic [2:0] state_o
);

  localparam int unsigned TMR_MAX = max3(SETTLE_CYC, ACK_WIDTH_CYC, VERIFY_CYC);
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned RW      = $clog2(RETRY_MAX + 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic [7:0]    trip_q, trip_d;
  logic          ack_n_q, ack_n_d;
  logic          run_ok_q, run_ok_d;
  logic          fault_q, fault_d;
  logic          kick_active, kick_inh;

  assign tmr_inc   = tmr_q + TW'(1);
  assign retry_inc = retry_q + RW'(1);

  // One shared timer serves SETTLE, ACK and VERIFY; it is zeroed on every state change.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    trip_d  = trip_q;
    if (!enable && (state_q != ST_LOCKOUT)) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          tmr_d   = '0;
        end
        ST_SETTLE: begin
          if (estop_a_n && estop_b_n) begin
            if (tmr_inc == TW'(SETTLE_CYC)) begin
              state_d = ST_ACK;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_inc;
            end
          end else begin
            tmr_d = '0;
          end
        end
        ST_ACK: begin
          if (tmr_inc == TW'(ACK_WIDTH_CYC)) begin
            state_d = ST_VERIFY;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        ST_VERIFY: begin
          if (!shutdown_in) begin
            state_d = ST_RUN;
            tmr_d   = '0;
            retry_d = '0;
          end else if (tmr_inc == TW'(VERIFY_CYC)) begin
            tmr_d   = '0;
            retry_d = retry_inc;
            state_d = (retry_inc == RW'(RETRY_MAX)) ? ST_LOCKOUT : ST_SETTLE;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        ST_RUN: begin
          if (shutdown_in) begin
            state_d = ST_TRIP;
            if (trip_q != 8'hFF) trip_d = trip_q + 8'd1;
          end
        end
        ST_TRIP: begin
          state_d = ST_SETTLE;
          tmr_d   = '0;
        end
        ST_LOCKOUT: begin
          if (fault_clr) begin
            state_d = ST_IDLE;
            retry_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
    ack_n_d  = (state_d != ST_ACK);
    run_ok_d = (state_d == ST_RUN);
    fault_d  = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      retry_q  <= '0;
      trip_q   <= '0;
      ack_n_q  <= 1'b1;
      run_ok_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      retry_q  <= retry_d;
      trip_q   <= trip_d;
      ack_n_q  <= ack_n_d;
      run_ok_q <= run_ok_d;
      fault_q  <= fault_d;
    end
  end

  assign kick_active = enable && (state_q != ST_LOCKOUT);
`ifdef ESD_SUP_KICK_INJECT_EN
  assign kick_inh = kick_inhibit;
`else
  assign kick_inh = 1'b0;
`endif

  esd_kick_gen #(
    .PERIOD_CYC(KICK_PERIOD_CYC),
    .WIDTH_CYC (KICK_WIDTH_CYC)
  ) u_kick_gen (
    .clk    (clk),
    .rst    (rst),
    .active (kick_active),
    .inhibit(kick_inh),
    .kick   (wdg_kick)
  );

  assign ack_n    = ack_n_q;
  assign run_ok   = run_ok_q;
  assign fault    = fault_q;
  assign trip_cnt = trip_q;
  assign state_o  = state_q;

endmodule
